itim_port_arbiter: RTL and testbench

- Shares the single-port instruction tightly-integrated memory (ITIM) between two requesters: instruction fetch (IFU) and load/store (LSU).
- LSU accesses cover rodata reads and loader/debug writes.
- The block sits between the core front-end/LSU and a synchronous-read block-RAM ITIM. It arbitrates, range-checks, gates writes, and routes the 1-cycle-latency read data back to the owning requester.

---
 rtl/itim_pkg.sv | 16 +
 rtl/itim_starve_ctr.sv | 35 +++
 rtl/itim_port_arbiter.sv | 122 ++++++++++++
 tb/tb_itim_port_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/itim_pkg.sv
// Shared types and constants for the ITIM port arbiter.
package itim_pkg;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam int unsigned ROM_ADDR_BITS_DEFAULT = 10;

  // Byte-address bit where the ITIM word index starts.
  localparam int unsigned WORD_LSB = 2;

  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/itim_starve_ctr.sv
// Saturating count of consecutive lost IFU arbitrations.
module itim_starve_ctr
  import itim_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != STARVE_CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == STARVE_CNT_W'(LIMIT));

endmodule

// File: rtl/itim_port_arbiter.sv
// Shares a single-port synchronous ITIM between instruction fetch and load/store,
// with range/alignment/write-lock checks and a fixed 1-cycle response path.
module itim_port_arbiter
  import itim_pkg::*;
#(
  parameter int unsigned ROM_ADDR_BITS = ROM_ADDR_BITS_DEFAULT,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ifu_req_valid,
  output logic                     ifu_req_ready,
  input  logic [31:0]              ifu_req_addr,
  output logic                     ifu_resp_valid,
  output logic [31:0]              ifu_resp_rdata,
  output logic                     ifu_resp_err,
  input  logic                     lsu_req_valid,
  output logic                     lsu_req_ready,
  input  logic [31:0]              lsu_req_addr,
  input  logic                     lsu_req_wen,
  input  logic [31:0]              lsu_req_wdata,
  input  logic [3:0]               lsu_req_wmask,
  output logic                     lsu_resp_valid,
  output logic [31:0]              lsu_resp_rdata,
  output logic                     lsu_resp_err,
  input  logic                     wr_unlock,
  output logic                     mem_valid,
  output logic [ROM_ADDR_BITS-1:0] mem_addr,
  output logic                     mem_wen,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wmask,
  input  logic [31:0]              mem_rdata
);

  localparam int unsigned TAG_LSB = ROM_ADDR_BITS + WORD_LSB;

  logic        hold_q;
  logic        block;
  logic        at_limit;
  logic        ifu_win, ifu_accept, lsu_accept, accept;
  logic [31:0] req_addr;
  logic        in_range, misaligned, wr_denied, req_err;
  owner_e      req_owner;

  logic        resp_valid_q, resp_err_q, resp_read_q;
  owner_e      resp_owner_q;

  // Requests stay blocked for one cycle after reset releases.
  always_ff @(posedge clk) begin
    hold_q <= reset;
  end

  assign block = reset | hold_q;

  assign ifu_win    = ifu_req_valid & (at_limit | ~lsu_req_valid);
  assign ifu_accept = ifu_win & ~block;
  assign lsu_accept = lsu_req_valid & ~ifu_win & ~block;
  assign accept     = ifu_accept | lsu_accept;

  assign ifu_req_ready = ifu_accept;
  assign lsu_req_ready = lsu_accept;

  itim_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk     (clk),
    .reset   (reset),
    .inc     (ifu_req_valid & ~ifu_accept),
    .clr     (block | ~ifu_req_valid | ifu_accept),
    .at_limit(at_limit)
  );

  assign req_owner  = lsu_accept ? OWN_LSU : OWN_IFU;
  assign req_addr   = lsu_accept ? lsu_req_addr : ifu_req_addr;
  assign in_range   = (req_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign misaligned = ifu_accept & (ifu_req_addr[1:0] != 2'b00);
  assign wr_denied  = lsu_accept & lsu_req_wen & ~wr_unlock;
  assign req_err    = ~in_range | misaligned | wr_denied;

  assign mem_valid = accept & ~req_err;
  assign mem_addr  = req_addr[TAG_LSB-1:WORD_LSB];
  assign mem_wen   = lsu_accept & lsu_req_wen;
  assign mem_wdata = lsu_accept ? lsu_req_wdata : 32'h0;
  assign mem_wmask = lsu_accept ? lsu_req_wmask : 4'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_read_q  <= 1'b0;
      resp_owner_q <= OWN_IFU;
    end else begin
      resp_valid_q <= accept;
      resp_err_q   <= accept & req_err;
      resp_read_q  <= accept & ~req_err & ~mem_wen;
      resp_owner_q <= req_owner;
    end
  end

  // Outputs are gated by reset so a pending response is dropped immediately.
  always_comb begin
    ifu_resp_valid = 1'b0;
    ifu_resp_err   = 1'b0;
    ifu_resp_rdata = 32'h0;
    lsu_resp_valid = 1'b0;
    lsu_resp_err   = 1'b0;
    lsu_resp_rdata = 32'h0;
    if (resp_valid_q && !reset) begin
      if (resp_owner_q == OWN_LSU) begin
        lsu_resp_valid = 1'b1;
        lsu_resp_err   = resp_err_q;
        lsu_resp_rdata = resp_read_q ? mem_rdata : 32'h0;
      end else begin
        ifu_resp_valid = 1'b1;
        ifu_resp_err   = resp_err_q;
        ifu_resp_rdata = resp_read_q ? mem_rdata : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_itim_port_arbiter.sv
// Directed and randomized bench for itim_port_arbiter against a transaction-level model.
module tb_itim_port_arbiter;

  localparam int unsigned RAB   = 10;
  localparam int unsigned LIMIT = 4;
  localparam int unsigned WORDS = 1 << RAB;

  logic            clk;
  logic            reset;
  logic            ifu_req_valid, ifu_req_ready;
  logic [31:0]     ifu_req_addr;
  logic            ifu_resp_valid, ifu_resp_err;
  logic [31:0]     ifu_resp_rdata;
  logic            lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [31:0]     lsu_req_addr, lsu_req_wdata;
  logic [3:0]      lsu_req_wmask;
  logic            lsu_resp_valid, lsu_resp_err;
  logic [31:0]     lsu_resp_rdata;
  logic            wr_unlock;
  logic            mem_valid, mem_wen;
  logic [RAB-1:0]  mem_addr;
  logic [31:0]     mem_wdata, mem_rdata;
  logic [3:0]      mem_wmask;

  itim_port_arbiter #(
    .ROM_ADDR_BITS(RAB),
    .BASE_ADDR    (32'h0000_0000),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_rdata(ifu_resp_rdata),
    .ifu_resp_err  (ifu_resp_err),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_req_addr  (lsu_req_addr),
    .lsu_req_wen   (lsu_req_wen),
    .lsu_req_wdata (lsu_req_wdata),
    .lsu_req_wmask (lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid),
    .lsu_resp_rdata(lsu_resp_rdata),
    .lsu_resp_err  (lsu_resp_err),
    .wr_unlock     (wr_unlock),
    .mem_valid     (mem_valid),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block RAM behind the arbiter: synchronous read, byte-masked write.
  logic [31:0] ram [WORDS];
  always @(posedge clk) begin
    if (mem_valid) begin
      if (mem_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wmask[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  // Reference model state: expected memory contents, lost-arbitration streak,
  // post-reset hold flag and the one response due next cycle.
  logic [31:0] model_mem [WORDS];
  int unsigned lost_m;
  logic        hold_m;
  logic        p_valid, p_lsu, p_err;
  logic [31:0] p_rdata;
  int          n_checks, n_errors;
  int          n_ifu_grants, n_lsu_grants;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic [31:0] ia,
                      input logic lv, input logic [31:0] la, input logic lw,
                      input logic [31:0] ld, input logic [3:0] lm, input logic un);
    logic        blk, ifu_wins, gi, gl, acc, err, good;
    logic [31:0] a, rd;
    int unsigned idx;
    @(posedge clk);
    #1;
    reset = r; ifu_req_valid = iv; ifu_req_addr = ia;
    lsu_req_valid = lv; lsu_req_addr = la; lsu_req_wen = lw;
    lsu_req_wdata = ld; lsu_req_wmask = lm; wr_unlock = un;
    #1;
    check("ifu_resp_valid", ifu_resp_valid, p_valid && !p_lsu && !r);
    check("ifu_resp_err", ifu_resp_err, p_valid && !p_lsu && !r && p_err);
    check("ifu_resp_rdata", ifu_resp_rdata, (p_valid && !p_lsu && !r) ? p_rdata : 32'h0);
    check("lsu_resp_valid", lsu_resp_valid, p_valid && p_lsu && !r);
    check("lsu_resp_err", lsu_resp_err, p_valid && p_lsu && !r && p_err);
    check("lsu_resp_rdata", lsu_resp_rdata, (p_valid && p_lsu && !r) ? p_rdata : 32'h0);

    blk      = r | hold_m;
    ifu_wins = iv & ((lost_m == LIMIT) | !lv);
    gi       = ifu_wins & !blk;
    gl       = lv & !ifu_wins & !blk;
    acc      = gi | gl;
    a        = gl ? la : ia;
    err      = (a[31:RAB+2] != 0) | (gi & (a[1:0] != 2'b00)) | (gl & lw & !un);
    good     = acc & !err;
    check("ifu_req_ready", ifu_req_ready, gi);
    check("lsu_req_ready", lsu_req_ready, gl);
    check("mem_valid", mem_valid, good);
    idx = a[RAB+1:2];
    if (good) begin
      check("mem_addr", 32'(mem_addr), idx);
      check("mem_wen", mem_wen, gl & lw);
    end
    rd = (good && !(gl && lw)) ? model_mem[idx] : 32'h0;
    if (good && gl && lw) begin
      for (int b = 0; b < 4; b++) begin
        if (lm[b]) model_mem[idx][8*b +: 8] = ld[8*b +: 8];
      end
    end
    if (gi) n_ifu_grants++;
    if (gl) n_lsu_grants++;
    p_valid = acc; p_lsu = gl; p_err = acc & err; p_rdata = rd;
    if (blk || !iv || gi) lost_m = 0;
    else if (lost_m < LIMIT) lost_m++;
    hold_m = r;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic ifu_rd(input logic [31:0] a);
    step(1'b0, 1'b1, a, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic lsu_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                        input logic un);
    step(1'b0, 1'b0, 32'h0, 1'b1, a, 1'b1, d, m, un);
  endtask

  initial begin
    logic [31:0] ia, la;
    n_checks = 0; n_errors = 0; n_ifu_grants = 0; n_lsu_grants = 0;
    lost_m = 0; hold_m = 1'b0; p_valid = 1'b0; p_lsu = 1'b0; p_err = 1'b0; p_rdata = 0;
    reset = 1'b1; ifu_req_valid = 0; ifu_req_addr = 0; lsu_req_valid = 0;
    lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0; wr_unlock = 0;
    for (int i = 0; i < int'(WORDS); i++) begin
      ram[i]       = (i + 1) * 32'h11;
      model_mem[i] = (i + 1) * 32'h11;
    end

    do_reset(); do_reset(); idle();
    ifu_rd(32'h0); ifu_rd(32'h4); ifu_rd(32'h8); idle();

    // Contention: both sides valid every cycle.
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 32'((i % 8) * 4), 1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 1'b0);
    end
    check("lsu_grants_under_contention", 32'(n_lsu_grants), 32'd10);
    check("ifu_grants_under_contention", 32'(n_ifu_grants), 32'd5);
    idle();

    lsu_wr(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
    lsu_wr(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
    ifu_rd(32'h10); idle();
    check("write_then_read_model", model_mem[4], 32'hDEAD_BEEF);

    ifu_rd(32'h2); ifu_rd(32'h1000); idle();

    lsu_wr(32'h14, 32'h1122_3344, 4'hF, 1'b1);
    lsu_wr(32'h14, 32'h0000_AB00, 4'b0010, 1'b1);
    ifu_rd(32'h14);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h14, 1'b0, 32'h0, 4'h0, 1'b0);
    idle();

    // Reset in the cycle after an accept drops the response.
    ifu_rd(32'h0); do_reset(); ifu_rd(32'h4); ifu_rd(32'h8); idle();

    for (int i = 0; i < 3000; i++) begin
      ia = 32'($urandom_range(0, 31)) << 2;
      la = 32'($urandom_range(0, 31)) << 2;
      if ($urandom_range(0, 7) == 0) ia[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) ia[12 + $urandom_range(0, 19)] = 1'b1;
      if ($urandom_range(0, 9) == 0) la[12 + $urandom_range(0, 19)] = 1'b1;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, ia,
           $urandom_range(0, 3) != 0, la, $urandom_range(0, 2) == 0, $urandom,
           4'($urandom), $urandom_range(0, 3) != 0);
    end
    idle(); idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
